// File: rtl/fpu_add_accum_seq.sv
// Operand sequencer in front of the FPU adder: reduces a stream of IEEE-754 singles
// per vector into one sum, bypassing zero operands the adder cannot represent.
module fpu_add_accum_seq #(
  parameter int ADD_LATENCY = 5,
  parameter int MAX_LEN     = 64,
  parameter int CNT_W       = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_last,
  output logic [31:0]      add_a,
  output logic [31:0]      add_b,
  output logic             add_start,
  input  logic [31:0]      add_result,
  input  logic [1:0]       add_warning,
  output logic             acc_valid,
  input  logic             acc_ready,
  output logic [31:0]      acc_data,
  output logic [CNT_W-1:0] acc_len,
  output logic [1:0]       acc_err
);

  // Both handshakes: a transfer happens on the rising edge where valid and ready are both 1;
  // a valid source holds its payload until that edge.

  localparam int LAT_W = $clog2(ADD_LATENCY + 1);

  typedef enum logic [2:0] {FLUSH, FIRST, NEXT, WAIT, OUT} state_t;

  state_t             state, state_nxt;
  logic [LAT_W-1:0]   lat_cnt;
  logic [31:0]        acc;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_inc;
  logic [1:0]         err;
  logic               last_f;
  logic               at_max;
  logic               in_zero;
  logic               acc_zero;
  logic               lat_done;

  assign cnt_inc  = cnt + 1'b1;
  assign at_max   = (cnt_inc == CNT_W'(MAX_LEN));
  assign in_zero  = (in_data[30:0] == '0);
  assign acc_zero = (acc[30:0] == '0);
  // lat_cnt is cleared on WAIT entry, so it equals the number of edges after the start edge
  assign lat_done = (lat_cnt == LAT_W'(ADD_LATENCY));

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    add_start = 1'b0;
    acc_valid = 1'b0;
    unique case (state)
      FLUSH: begin
        if (lat_cnt == LAT_W'(ADD_LATENCY - 1)) state_nxt = FIRST;
      end
      FIRST: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = in_last ? OUT : NEXT;
      end
      NEXT: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (!in_zero && !acc_zero)  state_nxt = WAIT;
          else if (in_last || at_max) state_nxt = OUT;
        end
      end
      WAIT: begin
        add_start = (lat_cnt == '0);
        if (lat_done) state_nxt = last_f ? OUT : NEXT;
      end
      OUT: begin
        acc_valid = 1'b1;
        if (acc_ready) state_nxt = FIRST;
      end
      default: state_nxt = FLUSH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= FLUSH;
      lat_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state)                lat_cnt <= '0;
      else if (state == FLUSH || state == WAIT) lat_cnt <= lat_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      cnt    <= '0;
      err    <= '0;
      last_f <= 1'b0;
      add_a  <= '0;
      add_b  <= '0;
    end else begin
      if (state == FIRST && in_valid) begin
        acc    <= in_data;
        cnt    <= CNT_W'(1);
        err    <= '0;
        last_f <= in_last;
      end
      if (state == NEXT && in_valid) begin
        cnt    <= cnt_inc;
        last_f <= in_last | at_max;
        if (at_max && !in_last) err[1] <= 1'b1;
        // A zero accumulator is replaced outright, dropping the sign of zero
        if (!in_zero) begin
          if (acc_zero) begin
            acc <= in_data;
          end else begin
            add_a <= acc;
            add_b <= in_data;
          end
        end
      end
      if (state == WAIT && lat_done) begin
        acc    <= add_result;
        err[0] <= err[0] | (|add_warning);
      end
    end
  end

  assign acc_data = acc;
  assign acc_len  = cnt;
  assign acc_err  = err;

endmodule

// File: tb/tb_fpu_add_accum_seq.sv
// Bench for fpu_add_accum_seq with a behavioural fixed-latency adder for positive normals.
module tb_fpu_add_accum_seq;
  localparam int LAT  = 5;
  localparam int MAXL = 4;
  localparam int CW   = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid, in_ready, in_last;
  logic [31:0]   in_data;
  logic [31:0]   add_a, add_b;
  logic          add_start;
  logic [31:0]   add_result = 32'h0;
  logic [1:0]    add_warning = 2'b00;
  logic          acc_valid, acc_ready;
  logic [31:0]   acc_data;
  logic [CW-1:0] acc_len;
  logic [1:0]    acc_err;

  int checks = 0;
  int failures = 0;
  int start_total = 0;

  always #5 clk = ~clk;

  fpu_add_accum_seq #(.ADD_LATENCY(LAT), .MAX_LEN(MAXL), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .add_a(add_a), .add_b(add_b), .add_start(add_start),
    .add_result(add_result), .add_warning(add_warning),
    .acc_valid(acc_valid), .acc_ready(acc_ready), .acc_data(acc_data),
    .acc_len(acc_len), .acc_err(acc_err)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp_v);
    end
  endtask

  // Same-sign positive normal addition with truncation
  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x, y;
    logic [7:0]  ex, d;
    logic [24:0] mx, my, s;
    if (a[30:23] >= b[30:23]) begin x = a; y = b; end
    else begin x = b; y = a; end
    ex = x[30:23];
    d  = x[30:23] - y[30:23];
    mx = {2'b01, x[22:0]};
    my = (d > 8'd24) ? 25'd0 : ({2'b01, y[22:0]} >> d);
    s  = mx + my;
    if (s[24]) begin s = s >> 1; ex = ex + 8'd1; end
    return {1'b0, ex, s[22:0]};
  endfunction

  // Adder model: result valid from the 4th edge after the start edge, garbage before
  logic [31:0] pa = 32'h0, pb = 32'h0;
  logic [1:0]  warn_val = 2'b00;
  int          pipe = 0;
  always @(posedge clk) begin
    if (!rst_n) begin
      pipe = 0;
    end else if (add_start) begin
      pa = add_a;
      pb = add_b;
      pipe = 1;
      add_result <= 32'hDEADBEEF;
      add_warning <= 2'b00;
    end else if (pipe > 0 && pipe < 5) begin
      if (pipe == 4) begin
        chk("operands_stable", {add_a, add_b}, {pa, pb});
        add_result <= fadd(pa, pb);
        add_warning <= warn_val;
      end
      pipe = pipe + 1;
    end
  end

  always @(negedge clk) if (add_start === 1'b1) start_total++;

  task automatic send(input logic [31:0] d, input logic l);
    int n;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("send_timeout", 64'(n), 64'(0));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_out(input string name);
    int n;
    n = 0;
    while (!acc_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk({name, "_out_timeout"}, 64'(n), 64'(0));
  endtask

  task automatic recv(input string name, input logic [31:0] d, input logic [CW-1:0] len,
                      input logic [1:0] err);
    @(negedge clk);
    wait_out(name);
    chk({name, "_data"}, 64'(acc_data), 64'(d));
    chk({name, "_len"}, 64'(acc_len), 64'(len));
    chk({name, "_err"}, 64'(acc_err), 64'(err));
    acc_ready = 1'b1;
    @(posedge clk);
    #1;
    acc_ready = 1'b0;
    chk({name, "_valid_drop"}, 64'(acc_valid), 64'(0));
  endtask

  task automatic check_flush(input string name);
    int n;
    chk({name, "_ready_at_release"}, 64'(in_ready), 64'(0));
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 20);
    chk({name, "_flush_cycles"}, 64'(n), 64'(LAT));
  endtask

  typedef struct packed {
    logic [3:0][31:0] d;
    logic [3:0]       l;
    logic [2:0]       n;
    logic [31:0]      exp_d;
    logic [CW-1:0]    len;
    logic [1:0]       err;
    logic [2:0]       starts;
  } vec_t;

  function automatic vec_t mk(input logic [31:0] d0, d1, d2, d3, input logic [3:0] l,
                              input logic [2:0] n, input logic [31:0] e,
                              input logic [CW-1:0] len, input logic [2:0] st);
    vec_t v;
    v.d = {d3, d2, d1, d0};
    v.l = l;
    v.n = n;
    v.exp_d = e;
    v.len = len;
    v.err = 2'b00;
    v.starts = st;
    return v;
  endfunction

  vec_t vt[7];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int s0, low, hi, n;
    in_valid = 1'b0;
    in_data = '0;
    in_last = 1'b0;
    acc_ready = 1'b0;

    vt[0] = mk(32'h3F800000, 32'h40000000, 32'h40400000, 0, 4'b0100, 3, 32'h40C00000, 3, 2);
    vt[1] = mk(32'h41200000, 0, 0, 0, 4'b0001, 1, 32'h41200000, 1, 0);
    vt[2] = mk(32'h00000000, 32'h3FC00000, 32'h00000000, 0, 4'b0100, 3, 32'h3FC00000, 3, 0);
    vt[3] = mk(32'h80000000, 32'h3F800000, 32'h40000000, 0, 4'b0100, 3, 32'h40400000, 3, 1);
    vt[4] = mk(32'h3F800000, 32'h00000000, 0, 0, 4'b0010, 2, 32'h3F800000, 2, 0);
    vt[5] = mk(32'h40000000, 32'h40000000, 32'h40800000, 0, 4'b0100, 3, 32'h41000000, 3, 2);
    vt[6] = mk(32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 4'b1000, 4,
               32'h40800000, 4, 3);

    #1;
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    chk("rst_acc_valid", 64'(acc_valid), 64'(0));
    chk("rst_add_start", 64'(add_start), 64'(0));
    chk("rst_add_ab", {add_a, add_b}, 64'(0));
    chk("rst_acc_data", 64'(acc_data), 64'(0));
    chk("rst_len_err", 64'({acc_len, acc_err}), 64'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_flush("init");

    for (int i = 0; i < 7; i++) begin
      s0 = start_total;
      for (int j = 0; j < int'(vt[i].n); j++) send(vt[i].d[j], vt[i].l[j]);
      recv($sformatf("vec%0d", i), vt[i].exp_d, vt[i].len, vt[i].err);
      chk($sformatf("vec%0d_starts", i), 64'(start_total - s0), 64'(vt[i].starts));
    end

    // Add timing and output hold with consumer stalled
    send(32'h3F800000, 1'b0);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 32'h40000000;
    in_last  = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    low = 0;
    hi = 0;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      low++;
      if (add_start) hi++;
      @(negedge clk);
      n++;
    end
    chk("ready_low_cycles", 64'(low), 64'(LAT + 1));
    chk("start_width", 64'(hi), 64'(1));
    send(32'h3F800000, 1'b1);
    @(negedge clk);
    wait_out("hold");
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("hold_valid", 64'(acc_valid), 64'(1));
      chk("hold_data", 64'(acc_data), 64'(32'h40800000));
      chk("hold_ready_low", 64'(in_ready), 64'(0));
    end
    recv("hold", 32'h40800000, 3'd3, 2'b00);

    // Length overflow closes the vector; the next element opens a fresh one
    s0 = start_total;
    for (int k = 0; k < 4; k++) send(32'h3F800000, 1'b0);
    recv("ovf", 32'h40800000, 3'd4, 2'b10);
    chk("ovf_starts", 64'(start_total - s0), 64'(3));
    send(32'h3F800000, 1'b0);
    send(32'h40000000, 1'b1);
    recv("ovf_next", 32'h40400000, 3'd2, 2'b00);

    // Adder warning is sticky for the vector
    warn_val = 2'b10;
    send(32'h3F800000, 1'b0);
    send(32'h3F800000, 1'b1);
    recv("warn", 32'h40000000, 3'd2, 2'b01);
    warn_val = 2'b00;

    // Reset while an add is in flight
    send(32'h3F800000, 1'b0);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 32'h40000000;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_start", 64'(add_start), 64'(0));
    chk("mid_rst_ready", 64'(in_ready), 64'(0));
    chk("mid_rst_add_ab", {add_a, add_b}, 64'(0));
    chk("mid_rst_acc", 64'({acc_data, acc_len, acc_err}), 64'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_flush("mid_rst");
    s0 = start_total;
    send(32'h3F800000, 1'b0);
    send(32'h3F800000, 1'b1);
    recv("post_rst", 32'h40000000, 3'd2, 2'b00);
    chk("post_rst_starts", 64'(start_total - s0), 64'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
